start_sequencer: RTL
====================

# start_sequencer

Avalon-MM slave that turns the 1-bit start level driven by the StartSignal PIO into a timed, handshaked run of the downstream datapath. It sits between the PIO `out_port` and the datapath's start/done pins. It applies a programmable launch delay, drives a fixed-width `go_out` pulse, and waits for `done_in` under an optional timeout. Sticky status flags, and an optional interrupt, are reported back to the Nios II.

## Interface
- `CNT_W`, 16: width of the DELAY and TIMEOUT registers and their counters (2..31).
- `PULSE_CYC`, 1: `go_out` high time in clk cycles (≥1).
- `clk` in 1: system clock, same domain as the PIO.
- `reset_n` in 1: asynchronous, active-low reset; clock is `clk`.
- `address` in 2: register select.
- `chipselect` in 1: slave select.
- `write_n` in 1: active-low write strobe.
- `writedata` in 32: write data.
- `readdata` out 32: combinational read data, zero wait states; unused bits 0.
- `start_in` in 1: start level from PIO `out_port`.
- `done_in` in 1: datapath completion, level or pulse.
- `go_out` out 1: start pulse to datapath; registered.
- `busy` out 1: high when the FSM is not in IDLE.
- `irq` out 1: interrupt; see Configuration.

## Operation
- Register map:
  - 0 STATUS, RO/W1C:
    - b0 busy (RO).
    - b1 done (sticky, W1C).
    - b2 timeout (sticky, W1C).
    - b3 overrun (sticky, W1C).
  - 1 CTRL:
    - b0 irq_en (RW).
    - b1 sw_start (WO, self-clearing, reads 0).
  - 2 DELAY[CNT_W-1:0], RW.
  - 3 TIMEOUT[CNT_W-1:0], RW. 0 means no timeout.
- Writes occur when `chipselect & ~write_n`.
- Trigger sources:
  - Rising edge of `start_in`, detected with register `start_d`.
  - A write of 1 to CTRL.b1.
  - Both sources in the same cycle count as one trigger.
- DELAY and TIMEOUT are latched into working counters at trigger time. Writes while busy affect only the next run.
- FSM states and transitions:
  - IDLE, on trigger: to DELAY with dcnt=DELAY. If DELAY=0, go directly to PULSE.
  - DELAY: dcnt decrements each cycle. At dcnt==1, go to PULSE.
  - PULSE: `go_out`=1 for PULSE_CYC cycles, then go to WAIT with tcnt=TIMEOUT.
  - WAIT, `done_in`=1: set done, go to IDLE.
  - WAIT, TIMEOUT≠0 and tcnt==1 with no `done_in`: set timeout, go to IDLE. tcnt decrements each WAIT cycle.
- `done_in` is ignored outside WAIT.
- If `done_in` and timeout expiry fall on the same cycle, done wins and timeout is not set.
- A trigger while busy is ignored and sets overrun; it does not restart the run.
- A hardware set and a W1C in the same cycle on the same bit: set wins.

## Timing
- Reset values:
  - state IDLE.
  - `go_out`=0, `busy`=0, `irq`=0.
  - All STATUS bits 0, irq_en 0.
  - DELAY=0, TIMEOUT=0.
  - `start_d`=1, so a `start_in` already high at reset release does not trigger.
- Reset asserted mid-run: immediate return to IDLE, `go_out` drops asynchronously, and no flag is set.
- Trigger sampled at edge T:
  - `go_out` is high during cycles T+DELAY+1 … T+DELAY+PULSE_CYC.
  - `busy` is high from T+1.
- `done_in` sampled high at WAIT edge E: `busy` is low and STATUS.done is set from E+1.
- Timeout fires on the TIMEOUT-th WAIT cycle without `done_in`.
- `readdata` reflects register state in the same cycle as the address; there is no read side effect.
- Counters are unsigned CNT_W bits. The maximum DELAY is 2^CNT_W−1 with no wrap.

## Configuration
- `START_SEQ_IRQ_EN` defined:
  - `irq` = irq_en & (done | timeout | overrun), registered.
  - `irq` is cleared one cycle after W1C of the causing bits.
- `START_SEQ_IRQ_EN` undefined:
  - `irq` tied 0.
  - CTRL.b0 is not implemented and reads 0.
  - STATUS behaviour is unchanged.

## Test plan
- DELAY=3, PULSE_CYC=1, TIMEOUT=0; `start_in` 0→1 at edge T → `go_out` high only in cycle T+4. `done_in` pulse 5 cycles later → STATUS reads 0x2, `busy`=0.
- DELAY=0, TIMEOUT=10, `done_in` never asserted → `go_out` at T+1, then STATUS.timeout set after 10 WAIT cycles. W1C 0x4 → STATUS reads 0x0.
- Second `start_in` edge during WAIT → no second `go_out`, STATUS.overrun=1, and the run completes normally on `done_in`.
- `start_in` held high through reset release → no trigger. CTRL write 0x2 → run starts, and CTRL reads 0x0 afterwards.
- `reset_n` asserted during DELAY, then released → `go_out` never pulses, `busy`=0, STATUS=0.
- With `START_SEQ_IRQ_EN`: irq_en=1, completed run → `irq`=1. W1C 0x2 → `irq`=0 the next cycle. Without the macro → `irq` stays 0.

Source files
------------

// File: rtl/start_sequencer.sv
// Avalon-MM start sequencer: turns a PIO start level into a delayed, fixed-width go pulse
// and waits for done with optional timeout. Define START_SEQ_IRQ_EN to enable the interrupt.
module start_sequencer #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned PULSE_CYC = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        start_in,
    input  logic        done_in,
    output logic        go_out,
    output logic        busy,
    output logic        irq
);

    localparam int unsigned PW = $clog2(PULSE_CYC + 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DELAY = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;
    localparam logic [1:0] ST_WAIT  = 2'd3;

    logic [1:0]       r_state, w_state_nxt;
    logic             r_start_d;
    logic [CNT_W-1:0] r_dcnt, w_dcnt_nxt;
    logic [CNT_W-1:0] r_tcnt, w_tcnt_nxt;
    logic [PW-1:0]    r_pcnt, w_pcnt_nxt;
    logic             r_go;
    logic [CNT_W-1:0] r_delay, r_timeout;
    logic             r_done, r_tout, r_ovr;
    logic             w_wr, w_trig, w_busy, w_set_done, w_set_tout, w_set_ovr;
    logic [2:0]       w_w1c;
    logic             w_irq_en;
    logic             w_unused;

    assign w_wr     = chipselect & ~write_n;
    // Edge and software start in the same cycle collapse into one trigger.
    assign w_trig   = (start_in & ~r_start_d) | (w_wr & (address == 2'd1) & writedata[1]);
    assign w_busy   = (r_state != ST_IDLE);
    assign w_set_ovr = w_trig & w_busy;
    assign w_w1c    = (w_wr && address == 2'd0) ? writedata[3:1] : 3'b000;
    assign w_unused = ^writedata;

    assign go_out = r_go;
    assign busy   = w_busy;

    always_comb begin
        w_state_nxt = r_state;
        w_dcnt_nxt  = r_dcnt;
        w_tcnt_nxt  = r_tcnt;
        w_pcnt_nxt  = r_pcnt;
        w_set_done  = 1'b0;
        w_set_tout  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_trig) begin
                    w_dcnt_nxt  = r_delay;
                    w_tcnt_nxt  = r_timeout;
                    w_pcnt_nxt  = PW'(PULSE_CYC);
                    w_state_nxt = (r_delay == '0) ? ST_PULSE : ST_DELAY;
                end
            end
            ST_DELAY: begin
                if (r_dcnt == CNT_W'(1)) w_state_nxt = ST_PULSE;
                else                     w_dcnt_nxt  = r_dcnt - CNT_W'(1);
            end
            ST_PULSE: begin
                if (r_pcnt == PW'(1)) w_state_nxt = ST_WAIT;
                else                  w_pcnt_nxt  = r_pcnt - PW'(1);
            end
            ST_WAIT: begin
                // done beats a simultaneous expiry; tcnt of 0 never expires
                if (done_in) begin
                    w_set_done  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tcnt == CNT_W'(1)) begin
                    w_set_tout  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_tcnt != '0) begin
                    w_tcnt_nxt  = r_tcnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_IDLE;
            r_start_d <= 1'b1;
            r_dcnt    <= '0;
            r_tcnt    <= '0;
            r_pcnt    <= '0;
            r_go      <= 1'b0;
            r_delay   <= '0;
            r_timeout <= '0;
            r_done    <= 1'b0;
            r_tout    <= 1'b0;
            r_ovr     <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_start_d <= start_in;
            r_dcnt    <= w_dcnt_nxt;
            r_tcnt    <= w_tcnt_nxt;
            r_pcnt    <= w_pcnt_nxt;
            r_go      <= (w_state_nxt == ST_PULSE);
            if (w_wr && address == 2'd2) r_delay   <= writedata[CNT_W-1:0];
            if (w_wr && address == 2'd3) r_timeout <= writedata[CNT_W-1:0];
            r_done    <= w_set_done | (r_done & ~w_w1c[0]);
            r_tout    <= w_set_tout | (r_tout & ~w_w1c[1]);
            r_ovr     <= w_set_ovr  | (r_ovr  & ~w_w1c[2]);
        end
    end

`ifdef START_SEQ_IRQ_EN
    logic r_irq_en, r_irq;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irq_en <= 1'b0;
            r_irq    <= 1'b0;
        end else begin
            if (w_wr && address == 2'd1) r_irq_en <= writedata[0];
            r_irq <= r_irq_en & (r_done | r_tout | r_ovr);
        end
    end

    assign w_irq_en = r_irq_en;
    assign irq      = r_irq;
`else
    assign w_irq_en = 1'b0;
    assign irq      = 1'b0;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata[3:0]       = {r_ovr, r_tout, r_done, w_busy};
            2'd1:    readdata[0]         = w_irq_en;
            2'd2:    readdata[CNT_W-1:0] = r_delay;
            default: readdata[CNT_W-1:0] = r_timeout;
        endcase
    end

endmodule
